hog_grad_sq: RTL and testbench
==============================

Name: hog_grad_sq

Overview:
- Upstream neighbour of the pipelined square-root stage in the HOG gradient path.
- Takes a streamed centre-pixel neighbourhood (left/right/up/down), computes gx = r - l and gy = d - u, and produces gx^2 + gy^2 for the sqrt input.
- Carries valid, row-end marker and signed gx/gy through a delay line so they emerge cycle-aligned with the sqrt result for downstream orientation binning.
- The sqrt stage has no handshake, so this block is free-running with valid tagging.

Parameters:
- PIX_W, 8, pixel width (unsigned).
- SQ_W, 2*PIX_W+2, width of the squared-magnitude output; equals the sqrt IN_W (18 at default).
- SQRT_LAT, 13, cycle latency of the downstream sqrt; must be >= 1.
- ROW_W, 160, pixels per row; must be >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  neighbourhood pixels valid this cycle.
- in_sof  in  1  start of frame; qualified by in_valid.
- pix_l, pix_r, pix_u, pix_d  in  PIX_W each  neighbour pixels.
- sq_out  out  SQ_W  gx^2+gy^2, feeds the sqrt input.
- sq_valid  out  1  sq_out carries a real pixel.
- al_valid  out  1  valid, aligned with the sqrt output.
- al_last  out  1  last pixel of row, aligned with the sqrt output.
- al_gx, al_gy  out  PIX_W+1 each  signed two's-complement gradients, aligned with the sqrt output.
- row_err  out  1  sticky: in_sof seen mid-row.

Behaviour:
- Reset: all pipeline, delay-line and counter registers clear asynchronously to 0. All outputs are 0.
- S1 register, loaded every clock:
  - gx = {0,pix_r} - {0,pix_l} and gy = {0,pix_d} - {0,pix_u}, each PIX_W+1 bits signed.
  - v1 = in_valid.
  - Last flag: set when the column counter equals ROW_W-1 and in_sof=0.
  - When in_valid=0, gx and gy are forced to 0.
- S2 register: sq_out = gx*gx + gy*gy, computed unsigned at full SQ_W width with no overflow. Maximum is 2*(2^PIX_W-1)^2 = 130050 at default. sq_valid = v1.
- Latency: in_valid at cycle t gives sq_valid at t+2.
- Delay line: a SQRT_LAT-deep shift register of {v, last, gx, gy} taken from S2. al_* at cycle t+2+SQRT_LAT match the sqrt output for that pixel. Bubbles propagate as valid=0 with all other fields 0.
- Column counter, width $clog2(ROW_W):
  - Advances only on in_valid.
  - in_sof with in_valid: the pixel is column 0 and the counter becomes 1.
  - Otherwise: at ROW_W-1 the counter wraps to 0 and the last flag is set; else it increments.
  - in_sof coincident with count ROW_W-1: in_sof wins, the pixel is column 0, no last flag.
- row_err: set when in_valid and in_sof arrive while the counter is non-zero. Cleared only by rst_n.
- in_sof without in_valid is ignored.
- No backpressure; every accepted pixel emerges exactly once.
- Reset mid-stream discards all in-flight pixels; no al_valid pulse appears afterwards until new input arrives.

Optional Feature:
- Macro HOG_GRAD_SIDEBAND_EN.
- Defined: al_gx and al_gy are carried through the delay line as above.
- Undefined: the gx/gy delay-line storage is omitted and al_gx/al_gy are tied to 0. sq_out, sq_valid, al_valid, al_last and row_err are unchanged.

Test Plan:
- Reset, then one pixel with l=10, r=40, u=100, d=60 -> sq_out=2500 with sq_valid at cycle +2; al_valid at +15 with al_gx=30, al_gy=-40 (0x1D8); sqrt output 50 at the same cycle.
- Extreme pixel with l=0, r=255, u=255, d=0 -> sq_out=130050, al_gx=255, al_gy=-255; all-equal pixels -> sq_out=0 with sq_valid=1.
- in_sof plus 160 consecutive valid pixels, then 160 more -> al_last high exactly on pixels 159 and 319; row_err stays 0.
- Stream with in_valid gaps (pattern 1,0,0,1,1,0) -> al_valid reproduces the same pattern 15 cycles later; sq_out=0 on bubbles.
- in_sof on column 37 -> that pixel is column 0 and row_err rises and stays high; in_sof coincident with column 159 -> no al_last and no row_err.
- Assert rst_n low while 5 pixels are in flight -> all outputs 0 immediately; no al_valid appears in the 20 cycles after release. Repeat the first scenario with HOG_GRAD_SIDEBAND_EN undefined -> al_gx=al_gy=0, other outputs identical.

Source files
------------

// File: rtl/hog_grad_sq.sv
// hog_grad_sq: HOG gradient squared magnitude ahead of the sqrt stage, with sqrt-aligned sideband.
// Optional macro HOG_GRAD_SIDEBAND_EN carries gx/gy through the delay line; otherwise al_gx/al_gy are 0.
module hog_grad_sq #(
    parameter int PIX_W    = 8,
    parameter int SQ_W     = 2*PIX_W+2,
    parameter int SQRT_LAT = 13,
    parameter int ROW_W    = 160
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [PIX_W-1:0]   pix_l,
    input  logic [PIX_W-1:0]   pix_r,
    input  logic [PIX_W-1:0]   pix_u,
    input  logic [PIX_W-1:0]   pix_d,
    output logic [SQ_W-1:0]    sq_out,
    output logic               sq_valid,
    output logic               al_valid,
    output logic               al_last,
    output logic [PIX_W:0]     al_gx,
    output logic [PIX_W:0]     al_gy,
    output logic               row_err
);
    localparam int CW = $clog2(ROW_W);
    localparam logic [CW-1:0] COL_LAST = CW'(ROW_W-1);

    logic [CW-1:0]         col_q, col_d;
    logic                  row_err_q, row_err_d;
    logic                  v1_q, v1_d, last1_q, last1_d;
    logic signed [PIX_W:0] gx1_q, gx1_d, gy1_q, gy1_d;
    logic [PIX_W:0]        ax, ay;
    logic [SQ_W-1:0]       sq_q, sq_d;
    logic                  v2_q, v2_d, last2_q, last2_d;
    logic                  dv_q [SQRT_LAT];
    logic                  dv_d [SQRT_LAT];
    logic                  dl_q [SQRT_LAT];
    logic                  dl_d [SQRT_LAT];

    always_comb begin
        gx1_d     = in_valid ? $signed({1'b0, pix_r}) - $signed({1'b0, pix_l}) : '0;
        gy1_d     = in_valid ? $signed({1'b0, pix_d}) - $signed({1'b0, pix_u}) : '0;
        v1_d      = in_valid;
        last1_d   = in_valid && !in_sof && col_q == COL_LAST;
        col_d     = !in_valid ? col_q : in_sof ? CW'(1) : col_q == COL_LAST ? '0 : col_q + 1'b1;
        row_err_d = row_err_q | (in_valid & in_sof & (col_q != '0));
        // Squaring via magnitudes keeps the arithmetic unsigned at full output width.
        ax        = gx1_q[PIX_W] ? -gx1_q : gx1_q;
        ay        = gy1_q[PIX_W] ? -gy1_q : gy1_q;
        sq_d      = SQ_W'(ax) * SQ_W'(ax) + SQ_W'(ay) * SQ_W'(ay);
        v2_d      = v1_q;
        last2_d   = last1_q;
        dv_d[0]   = v2_q;
        dl_d[0]   = last2_q;
        for (int i = 1; i < SQRT_LAT; i++) begin
            dv_d[i] = dv_q[i-1];
            dl_d[i] = dl_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_err_q <= 1'b0;
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            gx1_q     <= '0;
            gy1_q     <= '0;
            sq_q      <= '0;
            v2_q      <= 1'b0;
            last2_q   <= 1'b0;
            for (int i = 0; i < SQRT_LAT; i++) begin
                dv_q[i] <= 1'b0;
                dl_q[i] <= 1'b0;
            end
        end else begin
            col_q     <= col_d;
            row_err_q <= row_err_d;
            v1_q      <= v1_d;
            last1_q   <= last1_d;
            gx1_q     <= gx1_d;
            gy1_q     <= gy1_d;
            sq_q      <= sq_d;
            v2_q      <= v2_d;
            last2_q   <= last2_d;
            for (int i = 0; i < SQRT_LAT; i++) begin
                dv_q[i] <= dv_d[i];
                dl_q[i] <= dl_d[i];
            end
        end
    end

`ifdef HOG_GRAD_SIDEBAND_EN
    logic [PIX_W:0] gx2_q, gx2_d, gy2_q, gy2_d;
    logic [PIX_W:0] dgx_q [SQRT_LAT];
    logic [PIX_W:0] dgx_d [SQRT_LAT];
    logic [PIX_W:0] dgy_q [SQRT_LAT];
    logic [PIX_W:0] dgy_d [SQRT_LAT];

    always_comb begin
        gx2_d    = gx1_q;
        gy2_d    = gy1_q;
        dgx_d[0] = gx2_q;
        dgy_d[0] = gy2_q;
        for (int i = 1; i < SQRT_LAT; i++) begin
            dgx_d[i] = dgx_q[i-1];
            dgy_d[i] = dgy_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx2_q <= '0;
            gy2_q <= '0;
            for (int i = 0; i < SQRT_LAT; i++) begin
                dgx_q[i] <= '0;
                dgy_q[i] <= '0;
            end
        end else begin
            gx2_q <= gx2_d;
            gy2_q <= gy2_d;
            for (int i = 0; i < SQRT_LAT; i++) begin
                dgx_q[i] <= dgx_d[i];
                dgy_q[i] <= dgy_d[i];
            end
        end
    end

    assign al_gx = dgx_q[SQRT_LAT-1];
    assign al_gy = dgy_q[SQRT_LAT-1];
`else
    assign al_gx = '0;
    assign al_gy = '0;
`endif

    assign sq_out   = sq_q;
    assign sq_valid = v2_q;
    assign al_valid = dv_q[SQRT_LAT-1];
    assign al_last  = dl_q[SQRT_LAT-1];
    assign row_err  = row_err_q;
endmodule

// File: tb/tb_hog_grad_sq.sv
// tb_hog_grad_sq: randomized and directed scoreboard bench for hog_grad_sq.
module tb_hog_grad_sq;
    localparam int PIX_W = 8;
    localparam int SQ_W  = 18;
    localparam int L     = 13;
    localparam int ROW_W = 160;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0, in_sof = 1'b0;
    logic [PIX_W-1:0] pix_l = '0, pix_r = '0, pix_u = '0, pix_d = '0;
    logic [SQ_W-1:0]  sq_out;
    logic             sq_valid, al_valid, al_last, row_err;
    logic [PIX_W:0]   al_gx, al_gy;

    hog_grad_sq #(.PIX_W(PIX_W), .SQ_W(SQ_W), .SQRT_LAT(L), .ROW_W(ROW_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .pix_l(pix_l), .pix_r(pix_r), .pix_u(pix_u), .pix_d(pix_d),
        .sq_out(sq_out), .sq_valid(sq_valid), .al_valid(al_valid), .al_last(al_last),
        .al_gx(al_gx), .al_gy(al_gy), .row_err(row_err)
    );

    typedef struct {
        int cyc;
        int sq;
        bit last;
        int gx;
        int gy;
    } exp_t;

    exp_t sq_sb[$];
    exp_t al_sb[$];
    int   checks = 0, errors = 0, cyc = 0, col_m = 0;
    bit   err_pending = 1'b0, err_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model's row_err becomes visible one clock after the offending pixel is captured.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) err_exp <= 1'b0;
        else        err_exp <= err_pending;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit sof, input int l, input int r, input int u, input int d);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v; in_sof = sof;
        pix_l = PIX_W'(l); pix_r = PIX_W'(r); pix_u = PIX_W'(u); pix_d = PIX_W'(d);
        if (v) begin
            if (sof) begin
                if (col_m != 0) err_pending = 1'b1;
                e.last = 1'b0;
                col_m  = 1;
            end else begin
                e.last = (col_m == ROW_W-1);
                col_m  = (col_m + 1) % ROW_W;
            end
            e.cyc = cyc;
            e.gx  = r - l;
            e.gy  = d - u;
            e.sq  = e.gx * e.gx + e.gy * e.gy;
            sq_sb.push_back(e);
            al_sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, $urandom_range(1), $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
    endtask

    task automatic rnd_pix(input bit sof);
        drive(1, sof, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        #1;
        chk("rst_now_sq_out", sq_out, 0);
        chk("rst_now_sq_valid", sq_valid, 0);
        chk("rst_now_al_valid", al_valid, 0);
        chk("rst_now_al_last", al_last, 0);
        chk("rst_now_al_gx", al_gx, 0);
        chk("rst_now_al_gy", al_gy, 0);
        chk("rst_now_row_err", row_err, 0);
        sq_sb.delete();
        al_sb.delete();
        col_m = 0;
        err_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            chk("rst_outputs", {sq_out, sq_valid, al_valid, al_last, al_gx, al_gy, row_err}, 0);
        end else begin
            if (sq_valid) begin
                if (sq_sb.size() == 0) chk("sq_unexpected_valid", 1, 0);
                else begin
                    e = sq_sb.pop_front();
                    chk("sq_latency", cyc, e.cyc + 2);
                    chk("sq_out", sq_out, e.sq);
                end
            end else chk("sq_bubble", sq_out, 0);
            if (al_valid) begin
                if (al_sb.size() == 0) chk("al_unexpected_valid", 1, 0);
                else begin
                    e = al_sb.pop_front();
                    chk("al_latency", cyc, e.cyc + 2 + L);
                    chk("al_last", al_last, e.last);
`ifdef HOG_GRAD_SIDEBAND_EN
                    chk("al_gx", $signed(al_gx), e.gx);
                    chk("al_gy", $signed(al_gy), e.gy);
`else
                    chk("al_gx", al_gx, 0);
                    chk("al_gy", al_gy, 0);
`endif
                end
            end else chk("al_bubble", {al_last, al_gx, al_gy}, 0);
            chk("row_err", row_err, err_exp);
        end
    end

    initial begin
        bit gap_pat [6] = '{1, 0, 0, 1, 1, 0};
        #1 rst_n = 1'b0;
        do_reset();
        drive(1, 1, 10, 40, 100, 60);
        idle(2);
        chk("first_sq_2500", sq_out, 2500);
        idle(13);
        chk("first_al_valid", al_valid, 1);
`ifdef HOG_GRAD_SIDEBAND_EN
        chk("first_al_gy_1d8", al_gy, 9'h1D8);
`else
        chk("first_al_gy_zero", al_gy, 0);
`endif
        drive(1, 0, 0, 255, 255, 0);
        drive(1, 0, 77, 77, 77, 77);
        idle(20);

        do_reset();
        rnd_pix(1);
        for (int i = 1; i < 2*ROW_W; i++) rnd_pix(0);
        idle(20);
        chk("row_err_clean_rows", row_err, 0);

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 6; i++)
                if (gap_pat[i]) rnd_pix(0); else idle(1);
        idle(20);

        do_reset();
        rnd_pix(1);
        for (int i = 1; i < 37; i++) rnd_pix(0);
        rnd_pix(1);
        idle(3);
        chk("row_err_raised", row_err, 1);
        for (int i = 1; i < ROW_W-1; i++) rnd_pix(0);
        rnd_pix(1);
        for (int i = 1; i < ROW_W; i++) rnd_pix(0);
        idle(20);
        chk("row_err_sticky", row_err, 1);

        for (int i = 0; i < 5; i++) rnd_pix(0);
        do_reset();
        idle(20);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) < 7) rnd_pix($urandom_range(49) == 0);
            else idle(1);
        end
        idle(25);
        chk("drain_sq_queue", sq_sb.size(), 0);
        chk("drain_al_queue", al_sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
